// File: rtl/axis_mac_lanes_pkg.sv
// Shared widths and conv TUSER bit positions for the lane-parallel MAC stage.
package axis_mac_lanes_pkg;

  localparam int unsigned WORD_WIDTH     = 8;
  localparam int unsigned ACC_WIDTH      = 24;
  localparam int unsigned PROD_WIDTH     = 2 * WORD_WIDTH;
  localparam int unsigned TUSER_WIDTH    = 16;
  localparam int unsigned I_IS_SUM_START = 0;
  localparam int unsigned I_IS_CIN_LAST  = 1;
  localparam int unsigned I_IS_CONFIG    = 2;

  function automatic int unsigned prod_width(input int unsigned word_width);
    return 2 * word_width;
  endfunction

endpackage

// File: rtl/axis_mac_lanes_mac_lane.sv
// One MAC lane: registered signed product followed by a wrapping accumulator.
module mac_lane
  import axis_mac_lanes_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_WIDTH,
  parameter int unsigned ACC_W  = ACC_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              v1,
  input  logic              sum_start,
  input  logic              is_config,
  input  logic [WORD_W-1:0] pixel,
  input  logic [WORD_W-1:0] weight,
  output logic [ACC_W-1:0]  acc_next
);

  localparam int unsigned PW = prod_width(WORD_W);

  logic signed [PW-1:0]    prod_c;
  logic        [PW-1:0]    prod1;
  logic signed [ACC_W-1:0] prod_ext;
  logic        [ACC_W-1:0] acc;
  logic        [ACC_W-1:0] base;

  assign prod_c   = $signed(pixel) * $signed(weight);
  assign prod_ext = $signed(prod1);
  assign base     = sum_start ? '0 : acc;
  assign acc_next = base + prod_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod1 <= '0;
      acc   <= '0;
    end else if (ce) begin
      prod1 <= prod_c;
      if (v1 && !is_config) acc <= acc_next;
    end
  end

endmodule

// File: rtl/axis_mac_lanes.sv
// Lane-parallel signed MAC over the conv-input stream; emits one beat per channel sum.
module axis_mac_lanes #(
  parameter int unsigned LANES          = 8,
  parameter int unsigned WORD_WIDTH     = axis_mac_lanes_pkg::WORD_WIDTH,
  parameter int unsigned ACC_WIDTH      = axis_mac_lanes_pkg::ACC_WIDTH,
  parameter int unsigned TUSER_WIDTH    = axis_mac_lanes_pkg::TUSER_WIDTH,
  parameter int unsigned I_IS_SUM_START = axis_mac_lanes_pkg::I_IS_SUM_START,
  parameter int unsigned I_IS_CIN_LAST  = axis_mac_lanes_pkg::I_IS_CIN_LAST,
  parameter int unsigned I_IS_CONFIG    = axis_mac_lanes_pkg::I_IS_CONFIG
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  input  logic [TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic [LANES*WORD_WIDTH-1:0] s_axis_pixels_tdata,
  input  logic [LANES*WORD_WIDTH-1:0] s_axis_weights_tdata,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic [TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic [LANES*ACC_WIDTH-1:0]  m_axis_tdata
);

  logic                       ce;
  logic                       v1;
  logic                       last1;
  logic [TUSER_WIDTH-1:0]     user1;
  logic                       emit;
  logic [LANES*ACC_WIDTH-1:0] sums;

  // Whole pipeline stalls together, so the output register never drops a beat.
  assign ce            = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = ce;
  assign emit          = v1 && !user1[I_IS_CONFIG] && user1[I_IS_CIN_LAST];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(
      .WORD_W (WORD_WIDTH),
      .ACC_W  (ACC_WIDTH)
    ) u_lane (
      .clk       (aclk),
      .rst_n     (aresetn),
      .ce        (ce),
      .v1        (v1),
      .sum_start (user1[I_IS_SUM_START]),
      .is_config (user1[I_IS_CONFIG]),
      .pixel     (s_axis_pixels_tdata[i*WORD_WIDTH +: WORD_WIDTH]),
      .weight    (s_axis_weights_tdata[i*WORD_WIDTH +: WORD_WIDTH]),
      .acc_next  (sums[i*ACC_WIDTH +: ACC_WIDTH])
    );
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v1            <= 1'b0;
      last1         <= 1'b0;
      user1         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      m_axis_tdata  <= '0;
    end else if (ce) begin
      v1            <= s_axis_tvalid;
      user1         <= s_axis_tuser;
      last1         <= s_axis_tlast;
      m_axis_tvalid <= emit;
      if (emit) begin
        m_axis_tdata <= sums;
        m_axis_tuser <= user1;
        m_axis_tlast <= last1;
      end
    end
  end

endmodule

// File: tb/tb_axis_mac_lanes.sv
// Scoreboard bench for axis_mac_lanes: reference sums computed per accepted beat.
module tb_axis_mac_lanes;

  localparam int unsigned LANES = 8;
  localparam int unsigned WW    = 8;
  localparam int unsigned AW    = 24;
  localparam int unsigned UW    = 16;
  localparam int unsigned DW    = LANES * AW;

  typedef struct {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic          last;
  } exp_t;

  logic                aclk = 1'b0;
  logic                aresetn = 1'b0;
  logic                s_axis_tready;
  logic                s_axis_tvalid = 1'b0;
  logic                s_axis_tlast = 1'b0;
  logic [UW-1:0]       s_axis_tuser = '0;
  logic [LANES*WW-1:0] s_axis_pixels_tdata = '0;
  logic [LANES*WW-1:0] s_axis_weights_tdata = '0;
  logic                m_axis_tready = 1'b1;
  logic                m_axis_tvalid;
  logic                m_axis_tlast;
  logic [UW-1:0]       m_axis_tuser;
  logic [DW-1:0]       m_axis_tdata;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int          mode = 0;
  longint      msum [LANES];
  exp_t        sbq [$];

  always #5 aclk = ~aclk;

  axis_mac_lanes #(
    .LANES          (LANES),
    .WORD_WIDTH     (WW),
    .ACC_WIDTH      (AW),
    .TUSER_WIDTH    (UW),
    .I_IS_SUM_START (0),
    .I_IS_CIN_LAST  (1),
    .I_IS_CONFIG    (2)
  ) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_tready        (s_axis_tready),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tlast         (s_axis_tlast),
    .s_axis_tuser         (s_axis_tuser),
    .s_axis_pixels_tdata  (s_axis_pixels_tdata),
    .s_axis_weights_tdata (s_axis_weights_tdata),
    .m_axis_tready        (m_axis_tready),
    .m_axis_tvalid        (m_axis_tvalid),
    .m_axis_tlast         (m_axis_tlast),
    .m_axis_tuser         (m_axis_tuser),
    .m_axis_tdata         (m_axis_tdata)
  );

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [LANES*WW-1:0] fill(input logic [WW-1:0] v);
    logic [LANES*WW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*WW +: WW] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] fill_acc(input logic [AW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*AW +: AW] = v;
    return r;
  endfunction

  // Reference: per-lane running integer sums, updated for every accepted beat.
  task automatic model_accept(input logic [LANES*WW-1:0] pix, input logic [LANES*WW-1:0] wt,
                              input logic [UW-1:0] user, input logic last);
    exp_t e;
    longint p, w;
    if (user[2]) return;
    for (int i = 0; i < LANES; i++) begin
      p = longint'($signed(pix[i*WW +: WW]));
      w = longint'($signed(wt[i*WW +: WW]));
      if (user[0]) msum[i] = 0;
      msum[i] = msum[i] + p * w;
    end
    if (user[1]) begin
      for (int i = 0; i < LANES; i++) e.data[i*AW +: AW] = msum[i][AW-1:0];
      e.user = user;
      e.last = last;
      sbq.push_back(e);
    end
  endtask

  task automatic cycle_start();
    @(negedge aclk);
    case (mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      cycle_start();
      s_axis_tvalid = 1'b0;
    end
  endtask

  task automatic send_beat(input logic [LANES*WW-1:0] pix, input logic [LANES*WW-1:0] wt,
                           input logic [UW-1:0] user, input logic last);
    int tries = 0;
    logic ok;
    do begin
      cycle_start();
      s_axis_tvalid        = 1'b1;
      s_axis_pixels_tdata  = pix;
      s_axis_weights_tdata = wt;
      s_axis_tuser         = user;
      s_axis_tlast         = last;
      #1;
      ok = s_axis_tready;
      tries++;
      if (!ok && tries > 1000) begin
        $display("FAIL send_timeout: s_axis_tready stuck low");
        $fatal(1);
      end
    end while (!ok);
    model_accept(pix, wt, user, last);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      cycle_start();
      s_axis_tvalid = 1'b0;
      n++;
    end
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", sbq.size());
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  logic          stall = 1'b0;
  logic [DW-1:0] held_data;
  logic [UW-1:0] held_user;
  logic          held_last;

  always begin
    exp_t e;
    @(negedge aclk);
    #2;
    if (!aresetn) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("stall_valid", DW'(m_axis_tvalid), DW'(1));
        check("stall_data", m_axis_tdata, held_data);
        check("stall_user_last", DW'({m_axis_tuser, m_axis_tlast}), DW'({held_user, held_last}));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got data %h with no expected result", m_axis_tdata);
        end else begin
          e = sbq.pop_front();
          check("out_data", m_axis_tdata, e.data);
          check("out_user", DW'(m_axis_tuser), DW'(e.user));
          check("out_last", DW'(m_axis_tlast), DW'(e.last));
        end
      end
      stall     = m_axis_tvalid && !m_axis_tready;
      held_data = m_axis_tdata;
      held_user = m_axis_tuser;
      held_last = m_axis_tlast;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [LANES*WW-1:0] pix;
    logic [DW-1:0]       vec;
    logic [UW-1:0]       u;
    for (int i = 0; i < LANES; i++) msum[i] = 0;

    idle(3);
    check("rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    check("rst_m_tdata", m_axis_tdata, '0);
    check("rst_m_user_last", DW'({m_axis_tuser, m_axis_tlast}), '0);
    check("rst_s_tready", DW'(s_axis_tready), DW'(1));
    aresetn = 1'b1;
    idle(2);

    // Lane i: (i+1)*2 over three beats, plus a direct latency check.
    mode = 0;
    for (int i = 0; i < LANES; i++) pix[i*WW +: WW] = WW'(i + 1);
    send_beat(pix, fill(8'd2), 16'h0001, 1'b0);
    send_beat(pix, fill(8'd2), 16'h0000, 1'b0);
    send_beat(pix, fill(8'd2), 16'h0002, 1'b1);
    idle(1);
    #1 check("lat_after_accept_edge", DW'(m_axis_tvalid), DW'(0));
    idle(1);
    #1 check("lat_valid", DW'(m_axis_tvalid), DW'(1));
    for (int i = 0; i < LANES; i++) vec[i*AW +: AW] = AW'(6 * (i + 1));
    check("t1_direct", m_axis_tdata, vec);
    wait_drain();

    // One-beat sum of a negative product.
    send_beat(fill(8'hFD), fill(8'd5), 16'hA5F3, 1'b0);
    idle(2);
    #1 check("neg_direct", m_axis_tdata, fill_acc(24'hFFFFF1));
    check("neg_user", DW'(m_axis_tuser), DW'(16'hA5F3));
    wait_drain();

    // A config beat carrying every flag must be invisible to the sum.
    send_beat(fill(8'd1), fill(8'd1), 16'h0001, 1'b0);
    send_beat(fill(8'd1), fill(8'd1), 16'h0000, 1'b0);
    send_beat({$urandom, $urandom}, {$urandom, $urandom}, 16'h0007, 1'b1);
    send_beat(fill(8'd1), fill(8'd1), 16'h0000, 1'b0);
    send_beat(fill(8'd1), fill(8'd1), 16'h0002, 1'b1);
    idle(2);
    #1 check("config_direct", m_axis_tdata, fill_acc(24'd4));
    wait_drain();

    // Toggling backpressure over one-beat sums.
    mode = 1;
    for (int n = 0; n < 20; n++) begin
      u = 16'($urandom) & 16'hFFF8 | 16'h0003;
      send_beat({$urandom, $urandom}, {$urandom, $urandom}, u, 1'($urandom_range(0, 1)));
    end
    wait_drain();

    // Wraparound: 1024 * 16384 = 2^24.
    mode = 0;
    send_beat(fill(8'h80), fill(8'h80), 16'h0001, 1'b0);
    for (int n = 1; n < 1023; n++) send_beat(fill(8'h80), fill(8'h80), 16'h0000, 1'b0);
    send_beat(fill(8'h80), fill(8'h80), 16'h0002, 1'b1);
    idle(2);
    #1 check("overflow_direct", m_axis_tdata, fill_acc(24'd0));
    wait_drain();

    // Random flags, random backpressure.
    mode = 2;
    for (int n = 0; n < 60; n++) begin
      u = 16'($urandom);
      send_beat({$urandom, $urandom}, {$urandom, $urandom}, u, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    send_beat({$urandom, $urandom}, {$urandom, $urandom}, 16'h0003, 1'b1);
    wait_drain();

    // Reset in the middle of a sum discards it.
    mode = 0;
    send_beat(fill(8'd5), fill(8'd7), 16'h0001, 1'b0);
    send_beat(fill(8'd3), fill(8'd9), 16'h0000, 1'b0);
    cycle_start();
    s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    for (int i = 0; i < LANES; i++) msum[i] = 0;
    idle(2);
    check("midrst_tdata", m_axis_tdata, '0);
    check("midrst_tvalid", DW'(m_axis_tvalid), DW'(0));
    aresetn = 1'b1;
    send_beat(fill(8'd1), fill(8'd1), 16'h0000, 1'b0);
    send_beat(fill(8'd1), fill(8'd1), 16'h0002, 1'b1);
    idle(2);
    #1 check("post_rst_direct", m_axis_tdata, fill_acc(24'd2));
    wait_drain();

    idle(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
